// File: rtl/parity_pkg.sv
// parity_pkg: shared state encoding and default sizes for serial_parity_checker
package parity_pkg;
  typedef enum logic [1:0] {
    DATA = 2'd0,
    PAR  = 2'd1,
    OUT  = 2'd2
  } state_t;
  localparam int FRAME_LEN_DEF = 8;
  localparam int CNT_W_DEF = 8;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that wraps, or sticks at all-ones when sat_en=1
// Ports: clk, clr (sync active-high clear), inc (count enable), sat_en (saturate mode), cnt (value)
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  input  logic         sat_en,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk)
    if (clr) cnt <= '0;
    else if (inc && !(sat_en && &cnt)) cnt <= cnt + 1'b1;
endmodule

// File: rtl/serial_parity_checker.sv
// serial_parity_checker: frames a serial bit stream into FRAME_LEN data bits + parity and flags mismatches
// Ports: clk, rst (sync active-high); bit_in/bit_valid/bit_ready (serial input handshake);
//        out_valid/out_ready (result handshake) carrying frame_parity, parity_err;
//        frame_cnt (wrapping), err_cnt (saturating); err_sticky only when PARITY_STICKY_EN is defined
module serial_parity_checker
  import parity_pkg::*;
#(
  parameter int FRAME_LEN  = FRAME_LEN_DEF,
  parameter bit ODD_PARITY = 1'b0,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             bit_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             frame_parity,
  output logic             parity_err,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] err_cnt
`ifdef PARITY_STICKY_EN
  ,output logic            err_sticky
`endif
);
  localparam logic [7:0] LAST = 8'(FRAME_LEN - 1);
  state_t state, state_nxt;
  logic acc;
  logic [7:0] cnt;
  logic take, hs;
  assign take = bit_valid && bit_ready;
  assign hs = out_valid && out_ready;
  always_ff @(posedge clk)
    if (rst) state <= DATA;
    else state <= state_nxt;
  // The unused encoding falls through to DATA and keeps bit_ready low.
  always_comb begin
    state_nxt = DATA;
    bit_ready = 1'b0;
    bit_ready = (state == DATA) || (state == PAR);
    state_nxt = (state == DATA) ? ((take && cnt == LAST) ? PAR : DATA)
              : (state == PAR)  ? (take ? OUT : PAR)
              : (state == OUT)  ? (hs ? DATA : OUT)
              : DATA;
  end
  always_ff @(posedge clk)
    if (rst) begin
      acc          <= ODD_PARITY;
      cnt          <= '0;
      out_valid    <= 1'b0;
      frame_parity <= 1'b0;
      parity_err   <= 1'b0;
    end else begin
      if (state == DATA && take) begin
        acc <= acc ^ bit_in;
        cnt <= cnt + 8'd1;
      end
      if (state == PAR && take) begin
        frame_parity <= acc;
        parity_err   <= acc ^ bit_in;
        out_valid    <= 1'b1;
      end
      if (state == OUT && hs) begin
        out_valid <= 1'b0;
        acc       <= ODD_PARITY;
        cnt       <= '0;
      end
    end
  sat_counter #(.W(CNT_W)) u_frame_cnt (
    .clk(clk), .clr(rst), .inc(hs), .sat_en(1'b0), .cnt(frame_cnt)
  );
  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk(clk), .clr(rst), .inc(hs && parity_err), .sat_en(1'b1), .cnt(err_cnt)
  );
`ifdef PARITY_STICKY_EN
  always_ff @(posedge clk)
    if (rst) err_sticky <= 1'b0;
    else if (hs && parity_err) err_sticky <= 1'b1;
`endif
endmodule

// File: tb/tb_serial_parity_checker.sv
// tb_serial_parity_checker: scoreboard bench for serial_parity_checker (even-parity DUT plus odd-parity twin)
module tb_serial_parity_checker;
  localparam int FL = 8;
  logic clk = 1'b0, rst = 1'b1, bit_in = 1'b0, bit_valid = 1'b0, out_ready = 1'b1;
  logic bit_ready, out_valid, frame_parity, parity_err;
  logic [7:0] frame_cnt, err_cnt;
  logic o_ready, o_valid, o_fp, o_pe;
  logic [7:0] o_fc, o_ec;
`ifdef PARITY_STICKY_EN
  logic err_sticky, o_sticky;
`endif
  serial_parity_checker #(.FRAME_LEN(FL), .ODD_PARITY(1'b0), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready),
    .out_valid(out_valid), .out_ready(out_ready), .frame_parity(frame_parity),
    .parity_err(parity_err), .frame_cnt(frame_cnt), .err_cnt(err_cnt)
`ifdef PARITY_STICKY_EN
    , .err_sticky(err_sticky)
`endif
  );
  serial_parity_checker #(.FRAME_LEN(FL), .ODD_PARITY(1'b1), .CNT_W(8)) dut_odd (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(o_ready),
    .out_valid(o_valid), .out_ready(out_ready), .frame_parity(o_fp),
    .parity_err(o_pe), .frame_cnt(o_fc), .err_cnt(o_ec)
`ifdef PARITY_STICKY_EN
    , .err_sticky(o_sticky)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {
    logic       fp;
    logic       pe;
    logic [7:0] fc;
    logic [7:0] ec;
  } exp_t;
  exp_t q[$];
  exp_t e_mon;
  int n_chk = 0, n_fail = 0, n_hs = 0, exp_hs = 0;
  logic [7:0] m_fc = '0, m_ec = '0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk)
    if (!rst && out_valid && out_ready) begin
      n_hs++;
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_result: got a result with empty scoreboard at %0t", $time);
      end else begin
        e_mon = q.pop_front();
        chk("frame_parity", frame_parity, e_mon.fp);
        chk("parity_err", parity_err, e_mon.pe);
        chk("frame_cnt_pre", frame_cnt, e_mon.fc);
        chk("err_cnt_pre", err_cnt, e_mon.ec);
      end
    end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send_bit(input logic b);
    int w = 0;
    bit_in = b;
    bit_valid = 1'b1;
    while (!bit_ready && w < 50) begin
      tick();
      w++;
    end
    if (w == 50) begin
      n_chk++;
      n_fail++;
      $display("FAIL bit_ready_timeout: got 0 expected 1 at %0t", $time);
    end
    tick();
    bit_valid = 1'b0;
  endtask
  task automatic send_frame(input logic [7:0] d, input logic p, input bit gaps);
    logic ep;
    for (int i = 0; i < FL; i++) begin
      send_bit(d[i]);
      if (gaps) tick();
    end
    ep = ^d;
    q.push_back('{ep, ep ^ p, m_fc, m_ec});
    exp_hs++;
    m_fc++;
    if ((ep ^ p) && m_ec != 8'hff) m_ec++;
    send_bit(p);
    chk("out_valid_latency", out_valid, 1'b1);
  endtask
  task automatic do_reset(input int n);
    rst = 1'b1;
    bit_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_hs -= q.size();
    q.delete();
    m_fc = '0;
    m_ec = '0;
  endtask
  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    do_reset(2);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_frame_cnt", frame_cnt, 8'd0);
    chk("rst_err_cnt", err_cnt, 8'd0);
    chk("rst_bit_ready", bit_ready, 1'b1);
`ifdef PARITY_STICKY_EN
    chk("rst_sticky", err_sticky, 1'b0);
`endif
    send_frame(8'b0100_1101, 1'b0, 1'b0);
    tick();
    chk("good_frame_cnt", frame_cnt, 8'd1);
    chk("good_err_cnt", err_cnt, 8'd0);
    send_frame(8'b0100_1101, 1'b1, 1'b0);
    tick();
    chk("bad_frame_cnt", frame_cnt, 8'd2);
    chk("bad_err_cnt", err_cnt, 8'd1);
`ifdef PARITY_STICKY_EN
    chk("sticky_set", err_sticky, 1'b1);
`endif
    send_frame(8'h03, 1'b0, 1'b0);
    tick();
    chk("after_good_err_cnt", err_cnt, 8'd1);
`ifdef PARITY_STICKY_EN
    chk("sticky_held", err_sticky, 1'b1);
`endif
    out_ready = 1'b0;
    send_frame(8'h07, 1'b1, 1'b0);
    bit_valid = 1'b1;
    bit_in = 1'b0;
    repeat (5) begin
      tick();
      chk("bp_out_valid", out_valid, 1'b1);
      chk("bp_bit_ready", bit_ready, 1'b0);
      chk("bp_frame_parity", frame_parity, 1'b1);
      chk("bp_parity_err", parity_err, 1'b0);
      chk("bp_frame_cnt", frame_cnt, 8'd3);
    end
    out_ready = 1'b1;
    tick();
    bit_valid = 1'b0;
    chk("bp_release_valid", out_valid, 1'b0);
    chk("bp_release_cnt", frame_cnt, 8'd4);
    send_frame(8'hA5, 1'b1, 1'b0);
    tick();
    chk("post_bp_frame_cnt", frame_cnt, 8'd5);
    chk("post_bp_err_cnt", err_cnt, 8'd2);
    send_frame(8'b0100_1101, 1'b0, 1'b1);
    tick();
    chk("gap_frame_cnt", frame_cnt, 8'd6);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    do_reset(1);
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_frame_cnt", frame_cnt, 8'd0);
    send_frame(8'hFF, 1'b0, 1'b0);
    chk("ff_parity_err", parity_err, 1'b0);
    tick();
    chk("ff_frame_cnt", frame_cnt, 8'd1);
    out_ready = 1'b0;
    send_frame(8'h01, 1'b1, 1'b0);
    do_reset(1);
    chk("outrst_out_valid", out_valid, 1'b0);
    out_ready = 1'b1;
    for (int i = 0; i < 256; i++) send_frame(8'h00, 1'b1, 1'b0);
    tick();
    chk("sat_err_cnt", err_cnt, 8'd255);
    chk("wrap_frame_cnt", frame_cnt, 8'd0);
    do_reset(1);
    send_frame(8'h00, 1'b1, 1'b0);
    chk("odd_frame_parity", o_fp, 1'b1);
    chk("odd_parity_err", o_pe, 1'b0);
    tick();
    chk("odd_frame_cnt", o_fc, 8'd1);
    chk("odd_err_cnt", o_ec, 8'd0);
    tick();
    chk("results_seen", n_hs, exp_hs);
    chk("scoreboard_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/serial_parity_checker.md
Name: serial_parity_checker

Overview:
- Downstream consumer of the XOR gate's output: takes a serial bit stream (XOR result `y` or any 1-bit source) with a valid/ready handshake.
- Groups bits into frames of FRAME_LEN data bits followed by one parity bit.
- Computes the expected parity by XOR accumulation and flags a mismatch.
- Reports per-frame results on a held valid/ready output, plus running frame and error counters.

Parameters:
- FRAME_LEN, 8: data bits per frame, excluding the parity bit; legal range 1..255.
- ODD_PARITY, 0: 0 = even parity (parity bit = XOR of data); 1 = odd parity (parity bit = ~XOR of data).
- CNT_W, 8: width of frame_cnt and err_cnt.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: synchronous reset, active-high.
- bit_in, input, 1: serial data/parity bit.
- bit_valid, input, 1: bit_in valid this cycle.
- bit_ready, output, 1: checker can accept a bit.
- out_valid, output, 1: frame result available.
- out_ready, input, 1: downstream accepts the result.
- frame_parity, output, 1: expected parity computed from the data bits.
- parity_err, output, 1: received parity bit differed from expected.
- frame_cnt, output, CNT_W: frames reported (output handshakes); wraps.
- err_cnt, output, CNT_W: frames reported with parity_err=1; saturates.

Behaviour:
- Reset: one clock only; rst is synchronous and active-high, and is sampled on the rising edge of clk.
- Reset values: state=DATA, acc=ODD_PARITY, bit counter=0, out_valid=0, frame_parity=0, parity_err=0, frame_cnt=0, err_cnt=0.
- Accept: a bit is accepted only when bit_valid && bit_ready at the clock edge.
- bit_ready is combinational: 1 in DATA and PAR, 0 in OUT.
- DATA state:
  - On accept: acc <= acc ^ bit_in; cnt <= cnt+1.
  - When the accepted bit is number FRAME_LEN, go to PAR.
  - Idle cycles (bit_valid=0) leave all state unchanged; gaps are allowed anywhere.
- PAR state: on accept:
  - frame_parity <= acc.
  - parity_err <= acc ^ bit_in.
  - out_valid <= 1.
  - Go to OUT.
- OUT state:
  - out_valid, frame_parity and parity_err are held stable until out_ready=1.
  - bit_valid is ignored.
  - On out_valid && out_ready: out_valid <= 0; frame_cnt += 1 (wraps at 2^CNT_W); err_cnt += parity_err (saturates at 2^CNT_W-1); acc <= ODD_PARITY; cnt <= 0; go to DATA.
  - frame_parity and parity_err keep their last values after the handshake.
- Latency: out_valid rises on the clock edge that accepts the parity bit, i.e. it is visible the cycle after the parity-bit transfer.
- Throughput: with out_ready tied 1, one bubble per frame (the OUT cycle).
- Back-to-back case: out_ready is high in the same cycle as the OUT entry edge; the next bit is accepted the following cycle, because bit_ready is 0 in OUT for exactly one cycle.
- Reset mid-frame: the partial frame is discarded and the counters are cleared; there is no out_valid for the partial frame.
- Reset while in OUT: the pending result is dropped and out_valid=0 the next cycle.
- FRAME_LEN=1: DATA accepts one bit, then PAR.
- States are encoded as 2 bits; the unused encoding returns to DATA.

Optional Feature:
- Macro: PARITY_STICKY_EN.
- Defined:
  - Adds output port err_sticky (1 bit), reset to 0.
  - err_sticky is set on any output handshake with parity_err=1.
  - It is cleared only by rst.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package parity_pkg holds:
  - The state typedef: DATA=2'd0, PAR=2'd1, OUT=2'd2.
  - Default constants FRAME_LEN_DEF=8 and CNT_W_DEF=8.
- One sub-module, sat_counter:
  - Parameterised width; inputs inc and sat_en; synchronous active-high clear.
  - Instantiated twice: wrap mode for frame_cnt, saturate mode for err_cnt.

Test Plan (FRAME_LEN=8, ODD_PARITY=0 unless stated):
1. Reset: assert rst 2 cycles → out_valid=0, frame_cnt=0, err_cnt=0, bit_ready=1.
2. Good frame, contiguous: data 1,0,1,1,0,0,1,0 then parity 0, out_ready=1 → out_valid=1 one cycle after the parity bit; frame_parity=0, parity_err=0; frame_cnt=1, err_cnt=0.
3. Bad frame: same data, parity 1 → parity_err=1, err_cnt=1, frame_cnt=2; with PARITY_STICKY_EN, err_sticky=1 and it stays 1 through a later good frame.
4. Backpressure: good frame with out_ready=0 for 5 cycles while bit_valid=1 → out_valid, frame_parity and parity_err stable; bit_ready=0; no bits consumed. Release out_ready → next frame decodes correctly.
5. Gaps and mid-frame reset:
   - bit_valid toggled 1/0 across the frame → same result as scenario 2.
   - rst after 3 data bits, then a full frame with data 0xFF and parity 0 → parity_err=0, frame_cnt=1.
6. Counters and odd parity:
   - 256 consecutive bad frames with CNT_W=8 → err_cnt=255 (saturated), frame_cnt=0 (wrapped).
   - ODD_PARITY=1 with data 0x00 and parity 1 → parity_err=0, frame_parity=1.
